// File: rtl/lag_measure_multi_if.sv
// Signal bundle for lag_measure_multi: shared start/clear strobes, per-channel
// sensor triggers, and the packed per-channel measurement results.
interface lag_measure_multi_if #(
    parameter int CHANNELS    = 2,
    parameter int COUNT_WIDTH = 20
);
    // Handshake semantics: start, clear and sensor_trigger are single-cycle
    // strobes sampled on every clock edge (no back-pressure, always accepted).
    // sample_valid qualifies current/minimum/maximum for exactly one cycle;
    // avg_valid is a level qualifying average; timeout is sticky until start.
    logic                            start;
    logic                            clear;
    logic [CHANNELS-1:0]             sensor_trigger;
    logic [CHANNELS*COUNT_WIDTH-1:0] current;
    logic [CHANNELS*COUNT_WIDTH-1:0] minimum;
    logic [CHANNELS*COUNT_WIDTH-1:0] maximum;
    logic [CHANNELS*COUNT_WIDTH-1:0] average;
    logic [CHANNELS-1:0]             sample_valid;
    logic [CHANNELS-1:0]             avg_valid;
    logic [CHANNELS-1:0]             timeout;
    logic [CHANNELS-1:0]             fsm_state;
    logic                            busy;

    modport master (
        output start, clear, sensor_trigger,
        input  current, minimum, maximum, average,
        input  sample_valid, avg_valid, timeout, fsm_state, busy
    );

    modport slave (
        input  start, clear, sensor_trigger,
        output current, minimum, maximum, average,
        output sample_valid, avg_valid, timeout, fsm_state, busy
    );
endinterface

// File: rtl/lag_measure_multi.sv
// Multi-channel latency timer: one shared start arms every channel, each
// channel's trigger is timed in prescaled ticks and folded into min/max/average.
module lag_measure_multi #(
    parameter int CHANNELS    = 2,
    parameter int COUNT_WIDTH = 20,
    parameter int TICK_DIV    = 2700,
    parameter int AVG_LOG2    = 3,
    parameter int TIMEOUT     = 10000
) (
    input  logic             clock,
    input  logic             reset_n,
    lag_measure_multi_if.slave bus
);
    localparam int W     = COUNT_WIDTH;
    localparam int AVG_N = 1 << AVG_LOG2;
    localparam int SW    = W + AVG_LOG2;
    localparam int FW    = AVG_LOG2 + 1;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    logic [PW-1:0]       presc_q;
    logic [W-1:0]        elapsed_q;
    logic                tick;
    logic                at_timeout;

    state_t              state_q [CHANNELS];
    logic [CHANNELS-1:0] timeout_q;
    logic [CHANNELS-1:0] take;
    logic [CHANNELS-1:0] sample_valid_q;
    logic [CHANNELS-1:0] avg_valid_q;

    logic [W-1:0]        cur_q  [CHANNELS];
    logic [W-1:0]        min_q  [CHANNELS];
    logic [W-1:0]        max_q  [CHANNELS];
    logic [W-1:0]        avg_q  [CHANNELS];
    logic [SW-1:0]       sum_q  [CHANNELS];
    logic [FW-1:0]       fill_q [CHANNELS];
    logic [AVG_LOG2-1:0] ptr_q  [CHANNELS];
    logic [W-1:0]        ring_q [CHANNELS][AVG_N];

    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign at_timeout = (elapsed_q == W'(TIMEOUT));

    // Shared time base; start realigns it so the first tick lands TICK_DIV cycles later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            elapsed_q <= '0;
        end else if (bus.start) begin
            presc_q   <= '0;
            elapsed_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick && !(&elapsed_q)) begin
                elapsed_q <= elapsed_q + 1'b1;
            end
        end
    end

    // A sample is taken only from an armed channel, and start or clear in the same cycle drops it.
    always_comb begin
        take = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            take[k] = (state_q[k] == ARMED) && bus.sensor_trigger[k] && !bus.start && !bus.clear;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k]   <= IDLE;
                timeout_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (bus.start) begin
                    state_q[k]   <= ARMED;
                    timeout_q[k] <= 1'b0;
                end else if (state_q[k] == ARMED) begin
                    if (bus.sensor_trigger[k]) begin
                        state_q[k] <= IDLE;
                    end else if (at_timeout) begin
                        state_q[k]   <= IDLE;
                        timeout_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                sample_valid_q[k] <= 1'b0;
                avg_valid_q[k]    <= 1'b0;
                cur_q[k]          <= '0;
                min_q[k]          <= '1;
                max_q[k]          <= '0;
                avg_q[k]          <= '0;
                sum_q[k]          <= '0;
                fill_q[k]         <= '0;
                ptr_q[k]          <= '0;
                for (int j = 0; j < AVG_N; j++) begin
                    ring_q[k][j] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                sample_valid_q[k] <= take[k];
                if (bus.clear) begin
                    avg_valid_q[k] <= 1'b0;
                    cur_q[k]       <= '0;
                    min_q[k]       <= '1;
                    max_q[k]       <= '0;
                    avg_q[k]       <= '0;
                    sum_q[k]       <= '0;
                    fill_q[k]      <= '0;
                    ptr_q[k]       <= '0;
                    for (int j = 0; j < AVG_N; j++) begin
                        ring_q[k][j] <= '0;
                    end
                end else begin
                    if (take[k]) begin
                        cur_q[k] <= elapsed_q;
                        if (elapsed_q < min_q[k]) min_q[k] <= elapsed_q;
                        if (elapsed_q > max_q[k]) max_q[k] <= elapsed_q;
                        // Empty slots hold zero, so subtracting them is harmless while filling.
                        sum_q[k]            <= sum_q[k] + SW'(elapsed_q) - SW'(ring_q[k][ptr_q[k]]);
                        ring_q[k][ptr_q[k]] <= elapsed_q;
                        ptr_q[k]            <= ptr_q[k] + 1'b1;
                        if (fill_q[k] != FW'(AVG_N)) fill_q[k] <= fill_q[k] + 1'b1;
                    end
                    avg_valid_q[k] <= (fill_q[k] == FW'(AVG_N));
                    avg_q[k]       <= (fill_q[k] == FW'(AVG_N)) ? sum_q[k][SW-1:AVG_LOG2] : '0;
                end
            end
        end
    end

    always_comb begin
        bus.current      = '0;
        bus.minimum      = '0;
        bus.maximum      = '0;
        bus.average      = '0;
        bus.fsm_state    = '0;
        bus.busy         = 1'b0;
        bus.sample_valid = sample_valid_q;
        bus.avg_valid    = avg_valid_q;
        bus.timeout      = timeout_q;
        for (int k = 0; k < CHANNELS; k++) begin
            bus.current[k*W +: W] = cur_q[k];
            bus.minimum[k*W +: W] = min_q[k];
            bus.maximum[k*W +: W] = max_q[k];
            bus.average[k*W +: W] = avg_q[k];
            bus.fsm_state[k]      = (state_q[k] == ARMED);
            bus.busy              = bus.busy | (state_q[k] == ARMED);
        end
    end
endmodule

// File: tb/tb_lag_measure_multi.sv
// Bench for lag_measure_multi: directed scenarios plus randomized measurements,
// with a queue-based scoreboard fed by a tick-arithmetic reference model.
module tb_lag_measure_multi;
    localparam int CH      = 2;
    localparam int W       = 8;
    localparam int DIV     = 4;
    localparam int LOG2    = 2;
    localparam int TMO     = 200;

    logic clock;
    logic reset_n;

    lag_measure_multi_if #(.CHANNELS(CH), .COUNT_WIDTH(W)) bus ();

    lag_measure_multi #(
        .CHANNELS(CH), .COUNT_WIDTH(W), .TICK_DIV(DIV), .AVG_LOG2(LOG2), .TIMEOUT(TMO)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard queues: {ch, current, minimum, maximum} and {ch, avg_valid, average}
    logic [3*W:0] exp_q[$];
    logic [W+1:0] avg_q[$];

    // reference model
    int         edge_n;
    int         start_e;
    bit         start_seen;
    logic [1:0] m_armed;
    logic [1:0] m_to;
    int         m_cur[CH];
    int         m_min[CH];
    int         m_max[CH];
    int         m_hist[CH][$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_clear_stats();
        for (int k = 0; k < CH; k++) begin
            m_cur[k] = 0;
            m_min[k] = (1 << W) - 1;
            m_max[k] = 0;
            m_hist[k].delete();
        end
    endtask

    task automatic model_reset();
        m_armed    = '0;
        m_to       = '0;
        start_seen = 1'b0;
        start_e    = 0;
        model_clear_stats();
    endtask

    task automatic model_record(input int k, input int v);
        int sum;
        bit full;
        m_cur[k] = v;
        if (v < m_min[k]) m_min[k] = v;
        if (v > m_max[k]) m_max[k] = v;
        m_hist[k].push_back(v);
        if (m_hist[k].size() > (1 << LOG2)) void'(m_hist[k].pop_front());
        sum = 0;
        for (int i = 0; i < m_hist[k].size(); i++) sum += m_hist[k][i];
        full = (m_hist[k].size() == (1 << LOG2));
        exp_q.push_back({1'(k), W'(m_cur[k]), W'(m_min[k]), W'(m_max[k])});
        avg_q.push_back({1'(k), full, full ? W'(sum / (1 << LOG2)) : W'(0)});
    endtask

    // Applies the events sampled at clock edge e; elapsed is derived from edges since start.
    task automatic model_edge(input logic s, input logic c, input logic [1:0] tr, input int e);
        int el;
        el = start_seen ? (e - 1 - start_e) / DIV : 0;
        if (el > (1 << W) - 1) el = (1 << W) - 1;
        for (int k = 0; k < CH; k++) begin
            if (s) begin
                m_armed[k] = 1'b1;
                m_to[k]    = 1'b0;
            end else if (m_armed[k]) begin
                if (tr[k]) begin
                    m_armed[k] = 1'b0;
                    if (!c) model_record(k, el);
                end else if (el >= TMO) begin
                    m_armed[k] = 1'b0;
                    m_to[k]    = 1'b1;
                end
            end
        end
        if (c) model_clear_stats();
        if (s) begin
            start_e    = e;
            start_seen = 1'b1;
        end
    endtask

    // driver tasks: called #1 after a rising edge, return #1 after the next one
    task automatic step(input logic s, input logic c, input logic [1:0] tr);
        bus.start          = s;
        bus.clear          = c;
        bus.sensor_trigger = tr;
        @(posedge clock);
        edge_n++;
        model_edge(s, c, tr, edge_n);
        #1;
        bus.start          = 1'b0;
        bus.clear          = 1'b0;
        bus.sensor_trigger = '0;
        check("busy", bus.busy, int'(|m_armed));
        check("timeout", bus.timeout, m_to);
        check("fsm_state", bus.fsm_state, m_armed);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00);
    endtask

    // Fires the trigger in the cycle where elapsed equals v since the last start.
    task automatic trig_at(input int v, input logic [1:0] mask, input logic c);
        int target;
        target = start_e + 1 + DIV * v;
        while (edge_n < target - 1) step(1'b0, 1'b0, 2'b00);
        step(1'b0, c, mask);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_current"}, bus.current, 0);
        check({tag, "_minimum"}, bus.minimum, 16'hFFFF);
        check({tag, "_maximum"}, bus.maximum, 0);
        check({tag, "_average"}, bus.average, 0);
        check({tag, "_sample_valid"}, bus.sample_valid, 0);
        check({tag, "_avg_valid"}, bus.avg_valid, 0);
        check({tag, "_timeout"}, bus.timeout, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_fsm_state"}, bus.fsm_state, 0);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a sample
    initial begin
        logic [1:0]   pend;
        logic [1:0]   sv;
        logic [3*W:0] e;
        logic [W+1:0] a;
        pend = '0;
        forever begin
            @(negedge clock);
            for (int k = 0; k < CH; k++) begin
                if (pend[k]) begin
                    if (avg_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL avg_entry ch%0d: got none queued, required one", k);
                    end else begin
                        a = avg_q.pop_front();
                        check("avg_channel", k, a[W+1]);
                        check("avg_valid", bus.avg_valid[k], a[W]);
                        check("average", bus.average[k*W +: W], a[W-1:0]);
                    end
                end
            end
            sv = bus.sample_valid;
            for (int k = 0; k < CH; k++) begin
                if (sv[k]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_sample ch%0d: got sample_valid=1, required 0", k);
                    end else begin
                        e = exp_q.pop_front();
                        check("sample_channel", k, e[3*W]);
                        check("current", bus.current[k*W +: W], e[3*W-1:2*W]);
                        check("minimum", bus.minimum[k*W +: W], e[2*W-1:W]);
                        check("maximum", bus.maximum[k*W +: W], e[W-1:0]);
                    end
                end
            end
            pend = reset_n ? sv : 2'b00;
        end
    end

    // stimulus
    initial begin
        int         tgt[CH];
        logic [1:0] en;
        logic [1:0] mask;
        int         last;
        int         op;

        reset_n            = 1'b0;
        bus.start          = 1'b0;
        bus.clear          = 1'b0;
        bus.sensor_trigger = '0;
        edge_n             = 0;
        model_reset();
        repeat (3) @(negedge clock);
        check_reset_values("in_reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_reset_values("after_reset");

        // first measurement: start, trigger channel 0 at cycle 41
        step(1'b1, 1'b0, 2'b00);
        idle(40);
        step(1'b0, 1'b0, 2'b01);
        check("first_current0", bus.current[7:0], 10);
        check("first_min0", bus.minimum[7:0], 10);
        check("first_max0", bus.maximum[7:0], 10);
        check("first_sample_valid", bus.sample_valid, 2'b01);
        check("first_busy", bus.busy, 1);

        // fill channel 0's window: 10, 20, 30, 41 then 1
        step(1'b1, 1'b0, 2'b00); trig_at(20, 2'b01, 1'b0); idle(2);
        step(1'b1, 1'b0, 2'b00); trig_at(30, 2'b01, 1'b0); idle(2);
        step(1'b1, 1'b0, 2'b00); trig_at(41, 2'b01, 1'b0);
        check("avg_valid_not_yet", bus.avg_valid[0], 0);
        idle(1);
        check("avg_valid_rise", bus.avg_valid[0], 1);
        check("average_25", bus.average[7:0], 25);
        check("min_10", bus.minimum[7:0], 10);
        check("max_41", bus.maximum[7:0], 41);
        step(1'b1, 1'b0, 2'b00); trig_at(1, 2'b01, 1'b0); idle(1);
        check("average_23", bus.average[7:0], 23);
        idle(2);

        // timeout on both channels, then a new start clears the flags
        step(1'b1, 1'b0, 2'b00);
        idle(805);
        check("timeout_both", bus.timeout, 2'b11);
        check("timeout_busy_low", bus.busy, 0);
        step(1'b1, 1'b0, 2'b00);
        check("timeout_cleared", bus.timeout, 2'b00);

        // clear coincident with an accepted trigger
        trig_at(5, 2'b01, 1'b1);
        check("clear_no_sample", bus.sample_valid, 0);
        check("clear_current", bus.current, 0);
        check("clear_minimum", bus.minimum, 16'hFFFF);
        check("clear_maximum", bus.maximum, 0);
        check("clear_avg_valid", bus.avg_valid, 0);
        idle(2);

        // repeated trigger and trigger coincident with start are ignored
        step(1'b1, 1'b0, 2'b00);
        trig_at(2, 2'b01, 1'b0);
        check("recorded_2", bus.current[7:0], 2);
        idle(3);
        step(1'b0, 1'b0, 2'b01);
        check("second_trigger_ignored", bus.sample_valid, 0);
        step(1'b1, 1'b0, 2'b01);
        check("start_trigger_ignored", bus.sample_valid, 0);
        check("start_trigger_armed", bus.fsm_state, 2'b11);

        // simultaneous triggers at elapsed 7
        trig_at(7, 2'b11, 1'b0);
        check("dual_sample_valid", bus.sample_valid, 2'b11);
        check("dual_current0", bus.current[7:0], 7);
        check("dual_current1", bus.current[15:8], 7);
        idle(3);

        // asynchronous reset while armed with a partial window
        step(1'b1, 1'b0, 2'b00);
        idle(5);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        for (int v = 3; v <= 5; v++) begin
            step(1'b1, 1'b0, 2'b00); trig_at(v, 2'b01, 1'b0); idle(2);
        end
        check("refill_not_full", bus.avg_valid[0], 0);
        step(1'b1, 1'b0, 2'b00); trig_at(6, 2'b01, 1'b0); idle(1);
        check("refill_full", bus.avg_valid[0], 1);
        check("refill_average", bus.average[7:0], 4);
        idle(2);

        // randomized measurements, clears and occasional timeouts
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                step(1'b0, 1'b1, 2'b00);
                idle(2);
            end else if (op == 1) begin
                step(1'b1, 1'b0, 2'b00);
                idle(805);
            end else begin
                step(1'b1, 1'b0, 2'b00);
                last = start_e + 2;
                for (int k = 0; k < CH; k++) begin
                    en[k]  = ($urandom_range(0, 3) != 0);
                    tgt[k] = start_e + 1 + DIV * $urandom_range(0, 60) + $urandom_range(0, DIV - 1);
                    if (tgt[k] + 2 > last) last = tgt[k] + 2;
                end
                while (edge_n < last) begin
                    mask = '0;
                    for (int k = 0; k < CH; k++) begin
                        if (en[k] && tgt[k] == edge_n + 1) mask[k] = 1'b1;
                    end
                    if ($urandom_range(0, 49) == 0) mask[$urandom_range(0, 1)] = 1'b1;
                    step(1'b0, 1'b0, mask);
                end
                idle(2);
            end
        end

        idle(4);
        check("exp_q_drained", exp_q.size(), 0);
        check("avg_q_drained", avg_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lag_measure_multi.md
# lag_measure_multi

Multi-channel latency measurement engine, the parametrised successor to the single-sensor measurement block. One shared start event (the flash start, already crossed into the `clock` domain) arms every channel. The block times each channel's sensor trigger in prescaled ticks and keeps per-channel current/min/max and a sliding-window average. Outputs are binary; BCD conversion and clock-domain crossing to the video domain happen downstream.

## Interface
- `CHANNELS`, 2: number of sensor channels, 1..4.
- `COUNT_WIDTH`, 20: width of every time value in ticks.
- `TICK_DIV`, 2700: `clock` cycles per tick, ≥2.
- `AVG_LOG2`, 3: averaging window is 2^AVG_LOG2 samples, 1..4.
- `TIMEOUT`, 10000: tick count at which armed channels give up, < 2^COUNT_WIDTH−1.

Ports:
- `clock` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that starts a measurement on all channels.
- `clear` in 1: single-cycle pulse that clears all statistics (config change).
- `sensor_trigger` in CHANNELS: per-channel single-cycle detection pulses.
- `current` out CHANNELS*COUNT_WIDTH: last measured value per channel; channel k occupies bits [k*W +: W].
- `minimum` out CHANNELS*COUNT_WIDTH: smallest sample since clear.
- `maximum` out CHANNELS*COUNT_WIDTH: largest sample since clear.
- `average` out CHANNELS*COUNT_WIDTH: mean of the last 2^AVG_LOG2 samples.
- `sample_valid` out CHANNELS: one-cycle pulse when current/min/max update.
- `avg_valid` out CHANNELS: level, high once the averaging window is full.
- `timeout` out CHANNELS: sticky flag, channel timed out in the current measurement.
- `busy` out 1: high while any channel is ARMED.

## Operation
- Prescaler: counts 0..TICK_DIV−1. It emits `tick` on the cycle it holds TICK_DIV−1, then wraps. `start` forces it to 0.
- Elapsed counter: shared, W bits. `start` forces it to 0. Each `tick` increments it, saturating at 2^W−1.
- Per-channel FSM with states IDLE, ARMED.
  - IDLE→ARMED on `start`; `start` also clears that channel's `timeout`.
  - ARMED→IDLE on `sensor_trigger[k]`, which records a sample equal to elapsed in that cycle, before the increment.
  - ARMED→IDLE with `timeout[k]`=1 when elapsed==TIMEOUT. No sample is recorded.
  - In IDLE, triggers are ignored.
- Sample update for channel k: current←s; minimum←min(minimum,s); maximum←max(maximum,s); sample count is incremented.
- Averaging:
  - Each channel has a ring buffer of 2^AVG_LOG2 W-bit entries and a running sum of W+AVG_LOG2 bits: sum ← sum + s − oldest.
  - Fill counter saturates at 2^AVG_LOG2. `avg_valid` = fill full.
  - average = sum >> AVG_LOG2 (truncating). It reads 0 while `avg_valid`=0.
- `clear`: for all channels, current←0, minimum←all-ones, maximum←0, sum/fill/buffer←0, `avg_valid`←0. FSM state and `timeout` are unaffected.
- Simultaneous events:
  - `clear` with a trigger: clear wins, the sample is dropped, and no `sample_valid` is raised.
  - `start` with a trigger: the trigger is ignored and the channel ends ARMED with elapsed=0.
  - `start` with elapsed==TIMEOUT: start wins and no timeout is flagged.
  - Triggers on several channels in the same cycle are each recorded independently.
- `busy` = OR of ARMED states.

## Timing
- Reset values:
  - All outputs 0, except `minimum`, which is all-ones.
  - FSMs IDLE; prescaler and elapsed 0.
- Trigger accepted in cycle t:
  - `current`/`minimum`/`maximum` update and `sample_valid` pulses in t+1.
  - Sum and fill update in t+1; `average` and `avg_valid` update in t+2.
- `start` in cycle t: ARMED and `busy` from t+1. The first tick occurs in cycle t+TICK_DIV, so elapsed reads 1 from t+TICK_DIV+1.
- Timeout detected in cycle t: `timeout` set and state IDLE in t+1.
- `reset_n` asserted mid-measurement takes effect immediately, asynchronously. Deassertion is synchronised externally.

## Test plan
Bench parameters: CHANNELS=2, W=8, TICK_DIV=4, AVG_LOG2=2, TIMEOUT=200.
- Reset, then `start` at cycle 0 and `sensor_trigger[0]` at cycle 41. Required at cycle 42: current0=10, min0=10, max0=10, `sample_valid`=01. Channel 1 stays ARMED and `busy`=1.
- Four measurements on channel 0 with samples 10, 20, 30, 41. Required: `avg_valid0` rises 2 cycles after the 4th sample; average0=25; min0=10; max0=41. A 5th sample of 1 gives average0=23.
- `start` with no triggers. Required: both `timeout` bits set when elapsed reaches 200; `busy` falls; no `sample_valid` is raised. A later `start` clears `timeout`.
- `clear` in the same cycle as an accepted trigger. Required: no `sample_valid`; next cycle current=0, min=FF, max=0, `avg_valid`=0.
- A second trigger on channel 0 after the first, and a trigger on channel 0 coincident with `start`. Required: both are ignored, with no `sample_valid`.
- Triggers on both channels in the same cycle at elapsed=7. Required: `sample_valid`=11 and current0=current1=7.
- Assert `reset_n` while ARMED with a partial window. Required: all outputs return to reset values at once; the averaging fill restarts from 0.
